// File: rtl/present_mask_pkg.sv
// Shared constants and types for the masked PRESENT S-box share compressor.
package present_mask_pkg;

    localparam int NBITS   = 4;
    localparam int NTERMS  = 9;
    localparam int NSHARES = 3;
    localparam int RW      = NBITS * NTERMS;

    typedef struct packed {
        logic [NBITS-1:0] s3;
        logic [NBITS-1:0] s2;
        logic [NBITS-1:0] s1;
    } shares_t;

    function automatic int term_idx(input int g, input int k);
        return NTERMS * g + k;
    endfunction

endpackage

// File: rtl/present_ring_refresh9.sv
// Ring refresh of nine partial terms: each term gets r_k ^ r_(k+1 mod 9).
module present_ring_refresh9
    import present_mask_pkg::*;
(
    input  logic [NTERMS-1:0] cf_i,
    input  logic [NTERMS-1:0] rnd_i,
    output logic [NTERMS-1:0] t_o
);

    for (genvar k = 0; k < NTERMS; k++) begin : g_term
        assign t_o[k] = cf_i[k] ^ rnd_i[k] ^ rnd_i[(k + 1) % NTERMS];
    end

endmodule

// File: rtl/present_sbox_share_compress.sv
// Refresh, register, then compress 36 masked S-box terms into 3 shares
// of a 4-bit output through a two-stage valid/ready pipeline.
module present_sbox_share_compress
    import present_mask_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] cf_i,
    input  logic [RW-1:0] rnd_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NBITS-1:0] y_s1,
    output logic [NBITS-1:0] y_s2,
    output logic [NBITS-1:0] y_s3
);

    logic [RW-1:0] t_w;
    logic [RW-1:0] s1_q, s1_d;
    logic          s1_v_q, s1_v_d;
    logic          ov_q, ov_d;
    shares_t       y_q, y_d, y_c;
    logic          adv2, in_xfer;

    for (genvar g = 0; g < NBITS; g++) begin : g_grp
        present_ring_refresh9 u_rr (
            .cf_i  (cf_i[term_idx(g, 0) +: NTERMS]),
            .rnd_i (rnd_i[term_idx(g, 0) +: NTERMS]),
            .t_o   (t_w[term_idx(g, 0) +: NTERMS])
        );
    end

    assign adv2     = !ov_q | out_ready;
    assign in_ready = !s1_v_q | adv2;
    assign in_xfer  = in_valid & in_ready;

    // Compression only ever sees registered terms.
    always_comb begin
        y_c = '0;
        for (int g = 0; g < NBITS; g++) begin
            y_c.s1[g] = ^s1_q[term_idx(g, 0) +: 3];
            y_c.s2[g] = ^s1_q[term_idx(g, 3) +: 3];
            y_c.s3[g] = ^s1_q[term_idx(g, 6) +: 3];
        end
    end

    always_comb begin
        s1_d   = s1_q;
        s1_v_d = s1_v_q;
        if (in_xfer) begin
            s1_d   = t_w;
            s1_v_d = 1'b1;
        end else if (s1_v_q && adv2) begin
            s1_v_d = 1'b0;
        end
    end

    always_comb begin
        y_d  = y_q;
        ov_d = ov_q;
        if (adv2) begin
            ov_d = s1_v_q;
            if (s1_v_q) begin
                y_d = y_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s1_v_q <= 1'b0;
            ov_q   <= 1'b0;
            y_q    <= '0;
        end else begin
            s1_q   <= s1_d;
            s1_v_q <= s1_v_d;
            ov_q   <= ov_d;
            y_q    <= y_d;
        end
    end

    assign out_valid = ov_q;
    assign y_s1      = y_q.s1;
    assign y_s2      = y_q.s2;
    assign y_s3      = y_q.s3;

endmodule
